// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: latches rising edges of the device
// interrupt lines, masks them, and offers one fixed-priority request
// (lowest index wins) to the processor, with ack and end-of-interrupt.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding; waiting for an enabled pending bit
// ST_REQ     | irq asserted; irq_id follows the current candidate
// ST_SERVICE | request accepted; irq held low until an EOI write
module intr_controller #(
    parameter int                DBITS     = 32,
    parameter int                NUM_SRC   = 3,
    parameter logic [DBITS-1:0]  BASE_ADDR = 32'hF0000020
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBITS-1:0]   abus,
    inout  wire  [DBITS-1:0]   dbus,
    input  logic               we,
    input  logic [NUM_SRC-1:0] src_intr,
    input  logic               irq_ack,
    output logic               irq,
    output logic [1:0]         irq_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    localparam logic [DBITS-1:0] ADDR_PEND = BASE_ADDR;
    localparam logic [DBITS-1:0] ADDR_MASK = BASE_ADDR + DBITS'(4);
    localparam logic [DBITS-1:0] ADDR_ID   = BASE_ADDR + DBITS'(8);
    localparam logic [DBITS-1:0] ADDR_EOI  = BASE_ADDR + DBITS'(12);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] prev_src_q, prev_src_d;
    logic [1:0]         svc_id_q, svc_id_d;
    logic               irq_q, irq_d;
    logic [1:0]         irq_id_q, irq_id_d;

    logic               hit_pend, hit_mask, hit_id, hit_eoi;
    logic               wr_pend, wr_mask, wr_eoi;
    logic [NUM_SRC-1:0] act, rise, ack_clr;
    logic               cand_valid;
    logic [1:0]         cand_id;
    logic [DBITS-1:0]   rd_data;
    logic               unused_dbus_hi;

    assign hit_pend = (abus == ADDR_PEND);
    assign hit_mask = (abus == ADDR_MASK);
    assign hit_id   = (abus == ADDR_ID);
    assign hit_eoi  = (abus == ADDR_EOI);

    assign wr_pend = we & hit_pend;
    assign wr_mask = we & hit_mask;
    assign wr_eoi  = we & hit_eoi;

    assign act  = pend_q & mask_q;
    assign rise = src_intr & ~prev_src_q;

    // Only the low NUM_SRC data bits carry register content on writes.
    assign unused_dbus_hi = ^dbus[DBITS-1:NUM_SRC];

    // Fixed-priority pick: lowest enabled pending index.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                cand_valid = 1'b1;
                cand_id    = 2'(i);
            end
        end
    end

    // Read mux; the ID register reports the serviced source while in service.
    always_comb begin
        rd_data = '0;
        if (hit_pend) begin
            rd_data[NUM_SRC-1:0] = pend_q;
        end else if (hit_mask) begin
            rd_data[NUM_SRC-1:0] = mask_q;
        end else if (hit_id) begin
            rd_data[DBITS-1] = (state_q == ST_REQ) || (state_q == ST_SERVICE);
            rd_data[1:0]     = (state_q == ST_SERVICE) ? svc_id_q : cand_id;
        end
    end

    assign dbus = (!we && (hit_pend || hit_mask || hit_id || hit_eoi)) ? rd_data : 'z;

    // Next-state logic: FSM, register writes and pending-bit updates.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        prev_src_d = src_intr;
        svc_id_d   = svc_id_q;
        irq_d      = irq_q;
        irq_id_d   = irq_id_q;
        ack_clr    = '0;
        pend_d     = pend_q;

        if (wr_pend) pend_d = pend_d & ~dbus[NUM_SRC-1:0];
        if (wr_mask) mask_d = dbus[NUM_SRC-1:0];

        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (cand_valid) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    irq_id_d = cand_id;
                end
            end
            ST_REQ: begin
                // A request withdrawn by software wins over a late ack.
                if (!cand_valid) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end else if (irq_ack) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (irq_id_q == 2'(i)) ack_clr[i] = 1'b1;
                    end
                    svc_id_d = irq_id_q;
                    irq_d    = 1'b0;
                    state_d  = ST_SERVICE;
                end else begin
                    irq_id_d = cand_id;
                end
            end
            ST_SERVICE: begin
                irq_d = 1'b0;
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase

        // A fresh edge always survives a same-cycle clear.
        pend_d = (pend_d & ~ack_clr) | rise;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            mask_q     <= '0;
            prev_src_q <= '0;
            svc_id_q   <= '0;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            prev_src_q <= prev_src_d;
            svc_id_q   <= svc_id_d;
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
        end
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller using an expectation queue.
module tb_intr_controller;

    localparam logic [31:0] BASE   = 32'hF0000020;
    localparam logic [31:0] A_PEND = BASE;
    localparam logic [31:0] A_MASK = BASE + 32'd4;
    localparam logic [31:0] A_ID   = BASE + 32'd8;
    localparam logic [31:0] A_EOI  = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] abus;
    tri1  [31:0] dbus;
    logic        we;
    logic [2:0]  src_intr;
    logic        irq_ack;
    logic        irq;
    logic [1:0]  irq_id;

    logic        drv_en;
    logic [31:0] drv_data;

    assign dbus = drv_en ? drv_data : 'z;

    intr_controller #(.DBITS(32), .NUM_SRC(3), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .abus     (abus),
        .dbus     (dbus),
        .we       (we),
        .src_intr (src_intr),
        .irq_ack  (irq_ack),
        .irq      (irq),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, act, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        abus     = addr;
        we       = 1'b1;
        drv_en   = 1'b1;
        drv_data = data;
        tick();
        we       = 1'b0;
        drv_en   = 1'b0;
        abus     = 32'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        expect_val(tag, exp);
        abus = addr;
        we   = 1'b0;
        #1;
        v    = dbus;
        abus = 32'h0;
        observe(v);
    endtask

    task automatic irq_chk(input string tag, input logic exp_irq, input logic [1:0] exp_id);
        expect_val({tag, "_irq"}, {31'd0, exp_irq});
        expect_val({tag, "_id"}, {30'd0, exp_id});
        observe({31'd0, irq});
        observe({30'd0, irq_id});
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic src_pulse(input logic [2:0] s);
        src_intr = s;
        tick();
        src_intr = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        abus     = 32'h0;
        we       = 1'b0;
        src_intr = 3'b000;
        irq_ack  = 1'b0;
        drv_en   = 1'b0;
        drv_data = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state and bus release on a foreign address.
        rd_chk("rst_mask", A_MASK, 32'h0);
        rd_chk("rst_pend", A_PEND, 32'h0);
        rd_chk("rst_id", A_ID, 32'h0);
        rd_chk("hiz_miss", 32'hF0000000, 32'hFFFFFFFF);
        irq_chk("rst", 1'b0, 2'd0);

        // Single timer pulse: pend after k, request after k+1.
        bus_write(A_MASK, 32'h7);
        rd_chk("mask_rw", A_MASK, 32'h7);
        src_pulse(3'b100);
        rd_chk("tmr_pend", A_PEND, 32'h4);
        irq_chk("tmr_k", 1'b0, 2'd0);
        tick();
        irq_chk("tmr_k1", 1'b1, 2'd2);
        rd_chk("tmr_id", A_ID, 32'h80000002);
        rd_chk("eoi_read", A_EOI, 32'h0);
        ack_pulse();
        irq_chk("tmr_ack", 1'b0, 2'd2);
        rd_chk("tmr_svc_id", A_ID, 32'h80000002);
        rd_chk("tmr_pend_clr", A_PEND, 32'h0);
        bus_write(A_EOI, 32'h0);
        tick();
        irq_chk("tmr_eoi", 1'b0, 2'd2);
        rd_chk("tmr_idle_id", A_ID, 32'h0);

        // Key and timer together: key first, timer after EOI.
        src_pulse(3'b101);
        tick();
        irq_chk("dual_req", 1'b1, 2'd0);
        ack_pulse();
        irq_chk("dual_ack", 1'b0, 2'd0);
        rd_chk("dual_pend", A_PEND, 32'h4);
        bus_write(A_EOI, 32'hDEADBEEF);
        irq_chk("dual_eoi0", 1'b0, 2'd0);
        tick();
        irq_chk("dual_eoi1", 1'b1, 2'd2);
        ack_pulse();
        bus_write(A_EOI, 32'h1);
        rd_chk("dual_done_pend", A_PEND, 32'h0);

        // Masked switch edge, then enable, then software clear.
        bus_write(A_MASK, 32'h0);
        src_pulse(3'b010);
        rd_chk("msk_pend", A_PEND, 32'h2);
        tick();
        irq_chk("msk_off", 1'b0, 2'd2);
        bus_write(A_MASK, 32'h2);
        irq_chk("msk_on0", 1'b0, 2'd2);
        tick();
        irq_chk("msk_on1", 1'b1, 2'd1);
        bus_write(A_PEND, 32'h2);
        tick();
        irq_chk("w1c_drop", 1'b0, 2'd1);
        rd_chk("w1c_id", A_ID, 32'h0);
        rd_chk("w1c_pend", A_PEND, 32'h0);

        // Rise beats a same-cycle W1C; a later W1C with the line held clears.
        bus_write(A_MASK, 32'h0);
        abus     = A_PEND;
        we       = 1'b1;
        drv_en   = 1'b1;
        drv_data = 32'h2;
        src_intr = 3'b010;
        tick();
        we       = 1'b0;
        drv_en   = 1'b0;
        abus     = 32'h0;
        rd_chk("race_pend", A_PEND, 32'h2);
        bus_write(A_PEND, 32'h2);
        rd_chk("held_clr", A_PEND, 32'h0);
        src_intr = 3'b000;
        tick();

        // Asynchronous reset while in service with pending work.
        bus_write(A_MASK, 32'h7);
        src_pulse(3'b010);
        tick();
        irq_chk("svc_req", 1'b1, 2'd1);
        ack_pulse();
        src_pulse(3'b101);
        rd_chk("svc_pend", A_PEND, 32'h5);
        rd_chk("svc_id", A_ID, 32'h80000001);
        irq_chk("svc_irq", 1'b0, 2'd1);
        #1;
        reset = 1'b1;
        #1;
        irq_chk("arst", 1'b0, 2'd0);
        rd_chk("arst_pend", A_PEND, 32'h0);
        rd_chk("arst_mask", A_MASK, 32'h0);
        rd_chk("arst_id", A_ID, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
